// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default widths, reset PC, bubble encoding and
// the PCSrc encoding agreed with the hazard unit and controller.
package pipe_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // PCSrc encoding: 2'b00 is always the sequential PC+4 path.
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Per-edge action taken on the fetch PC.
  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_HOLD  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  // Per-edge action taken on the F/D latch.
  typedef enum logic [1:0] {
    FD_LOAD   = 2'd0,
    FD_HOLD   = 2'd1,
    FD_BUBBLE = 2'd2
  } fd_sel_e;

endpackage

// File: rtl/perf_cnt.sv
// Single free-running wrap-around event counter with enable.
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Increment once per enabled edge; wraps naturally at 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control consumer: fetch PC, F/D latch, E/M/W valid chain and
// performance counters, driven by the hazard unit's stall/flush outputs.
// Flush has priority over stall for both the PC and the F/D latch.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Fi_stall,
  input  logic             Di_stall,
  input  logic             Di_flush,
  input  logic             Ei_flush,
  input  logic [XLEN-1:0]  Ei_PCTarget,
  input  logic [31:0]      Fi_instr,
  output logic [XLEN-1:0]  Fo_PC,
  output logic [31:0]      Do_instr,
  output logic [XLEN-1:0]  Do_PC,
  output logic [XLEN-1:0]  Do_PCPlus4,
  output logic             Do_valid,
  output logic             Eo_valid,
  output logic             Mo_valid,
  output logic             Wo_valid,
  output logic [CNT_W-1:0] Oo_cycles,
  output logic [CNT_W-1:0] Oo_retired,
  output logic [CNT_W-1:0] Oo_stalls,
  output logic [CNT_W-1:0] Oo_flushes
);

  pc_sel_e pc_sel;
  fd_sel_e fd_sel;

  // Resolve hazard inputs into one action per register group; flush first.
  always_comb begin
    pc_sel = PC_SEQ;
    fd_sel = FD_LOAD;
    if (Di_flush) begin
      pc_sel = PC_REDIR;
    end else if (Fi_stall) begin
      pc_sel = PC_HOLD;
    end
    if (Di_flush) begin
      fd_sel = FD_BUBBLE;
    end else if (Di_stall) begin
      fd_sel = FD_HOLD;
    end
  end

  // Fetch PC: redirect, hold or advance by 4 (modulo 2^XLEN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fo_PC <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_REDIR: Fo_PC <= Ei_PCTarget;
        PC_HOLD:  Fo_PC <= Fo_PC;
        default:  Fo_PC <= Fo_PC + XLEN'(4);
      endcase
    end
  end

  // F/D latch: a bubble keeps Do_PC so the squashed slot still has a PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Do_instr <= NOP_INSTR;
      Do_PC    <= RESET_PC;
      Do_valid <= 1'b0;
    end else begin
      case (fd_sel)
        FD_BUBBLE: begin
          Do_instr <= NOP_INSTR;
          Do_valid <= 1'b0;
        end
        FD_HOLD: begin
          Do_instr <= Do_instr;
          Do_PC    <= Do_PC;
          Do_valid <= Do_valid;
        end
        default: begin
          Do_instr <= Fi_instr;
          Do_PC    <= Fo_PC;
          Do_valid <= 1'b1;
        end
      endcase
    end
  end

  // Link address for the D-stage instruction.
  assign Do_PCPlus4 = Do_PC + XLEN'(4);

  // Valid chain: only the D->E hop can be squashed; M and W just follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Eo_valid <= 1'b0;
      Mo_valid <= 1'b0;
      Wo_valid <= 1'b0;
    end else begin
      Eo_valid <= Ei_flush ? 1'b0 : Do_valid;
      Mo_valid <= Eo_valid;
      Wo_valid <= Mo_valid;
    end
  end

  // Performance counters, all sampled on the same edge.
  perf_cnt #(.W(CNT_W)) u_cnt_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .count (Oo_cycles)
  );

  perf_cnt #(.W(CNT_W)) u_cnt_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (Wo_valid),
    .count (Oo_retired)
  );

  perf_cnt #(.W(CNT_W)) u_cnt_stalls (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (Fi_stall),
    .count (Oo_stalls)
  );

  perf_cnt #(.W(CNT_W)) u_cnt_flushes (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (Di_flush),
    .count (Oo_flushes)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Consumer side of the hazard unit's stall/flush interface. It owns the fetch PC register, the F→D instruction/PC latch, and the per-stage valid bits for E/M/W. It applies Fo_stall/Do_stall/Do_flush/Eo_flush cycle by cycle, inserts NOP bubbles, redirects the PC on taken branches/jumps, and keeps pipeline performance counters. It sits between the hazard unit, the instruction memory port, and the D-stage datapath.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
Fi_stall  in  1  hold PC (from hazard)
Di_stall  in  1  hold F/D latch (from hazard)
Di_flush  in  1  squash F/D latch; also the PC-redirect request (NextPC != PC+4)
Ei_flush  in  1  squash the instruction entering E (bubble)
Ei_PCTarget  in  XLEN  redirect target computed in E
Fi_instr  in  32  instruction read from imem at Fo_PC (combinational read)
Fo_PC  out  XLEN  current fetch PC, to imem
Do_instr  out  32  D-stage instruction
Do_PC  out  XLEN  PC of D-stage instruction
Do_PCPlus4  out  XLEN  Do_PC + 4
Do_valid  out  1  D stage holds a real instruction
Eo_valid, Mo_valid, Wo_valid  out  1 each  stage valid bits
Oo_cycles  out  CNT_W  cycles since reset
Oo_retired  out  CNT_W  instructions retired (Wo_valid cycles)
Oo_stalls  out  CNT_W  cycles with Fi_stall=1
Oo_flushes  out  CNT_W  cycles with Di_flush=1

Behaviour:
- Reset, asynchronous on rst_n low: Fo_PC=RESET_PC; Do_instr=NOP_INSTR; Do_PC=RESET_PC; all valid bits 0; all counters 0. Reset asserted mid-operation clears everything immediately, with no drain.
- PC update per edge, in priority order:
  1. Di_flush → Fo_PC <= Ei_PCTarget.
  2. Else if Fi_stall → hold.
  3. Else → Fo_PC + 4.
  All PC arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0.
- F/D latch per edge, in priority order:
  1. Di_flush → Do_instr=NOP_INSTR, Do_valid=0, Do_PC unchanged.
  2. Else if Di_stall → hold all fields.
  3. Else → Do_instr=Fi_instr, Do_PC=Fo_PC, Do_valid=1.
- Flush beats stall whenever both are asserted in the same cycle.
- Do_PCPlus4 is combinational from Do_PC.
- Eo_valid <= Ei_flush ? 0 : Do_valid.
- Mo_valid <= Eo_valid; Wo_valid <= Mo_valid. M and W are never stalled or flushed.
- Latency: an instruction fetched at cycle n is in D at n+1, E at n+2, M at n+3, W at n+4, absent stalls.
- Load-use stall (Fi_stall=Di_stall=Ei_flush=1, Di_flush=0): PC and D hold; a bubble enters E.
- Taken branch (Di_flush=Ei_flush=1): PC redirects; D and E both become bubbles, a 2-cycle penalty.
- Fi_stall≠Di_stall is not a legal hazard-unit output. pipe_ctrl still applies each bit independently, with no special handling.
- Counters increment by 1 on their condition, wrap at 2^CNT_W, and all update in the same edge.
- Oo_cycles starts counting on the first edge after rst_n deasserts.
- First real fetch: at the first edge after reset, Fi_instr at RESET_PC is captured and Do_valid=1.

Decomposition:
- Shared package pipe_pkg holds: XLEN, RESET_PC, NOP_INSTR, and the PCSrc encoding constants (2'b00 = PC+4), which are shared with the hazard unit and controller.
- One natural sub-module: perf_cnt, a single wrap-around counter with en and async active-low reset, instantiated four times.
- PC, F/D latch and valid chain stay inline.

Test Plan:
1. Reset release, no hazards, imem returns PC-tagged words → Fo_PC 0,4,8,...; Do_valid=1 from cycle 1; Wo_valid first high at cycle 4; Oo_retired=6 after 10 cycles.
2. Load-use: assert Fi_stall=Di_stall=Ei_flush=1 for 1 cycle with Fo_PC=0x10 → Fo_PC stays 0x10 one extra cycle; Do_instr held; Eo_valid=0 next cycle; Oo_stalls=1.
3. Taken branch: Di_flush=Ei_flush=1, Ei_PCTarget=0x100 → next Fo_PC=0x100; Do_instr=0x0000_0013, Do_valid=0; Eo_valid=0; Oo_flushes=1; fetch resumes 0x104 after that.
4. Simultaneous Di_flush and Di_stall/Fi_stall with target 0x40 → flush wins: Fo_PC=0x40, D gets a bubble.
5. Assert rst_n low mid-run, asynchronously, between edges → outputs reach reset values before the next edge; Fo_PC=RESET_PC; counters 0.
6. Wrap: Ei_PCTarget=0xFFFF_FFFC via flush, then free-run → Fo_PC 0xFFFF_FFFC → 0x0000_0000. With CNT_W=4, 17 cycles → Oo_cycles=1.
